// File: rtl/perceptron_train_ctrl.sv
// Perceptron training sequencer: steps FETCH/ACC/BIAS/EVAL per sample, weight updates on error, epochs until converged or limit.
// Latency: error-free sample N_IN+3 cycles, sample with error 4*N_IN+5 cycles; done pulses one cycle in DONE.
// Backpressure: none; start is level-sensitive in IDLE/LOAD only, error is sampled only in EVAL.
module perceptron_train_ctrl #(
    parameter int N_IN    = 2,
    parameter int IDX_W   = (N_IN > 1) ? $clog2(N_IN) : 1,
    parameter int CNT_W   = 4,
    parameter int EPOCH_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [CNT_W-1:0]   n_samples,
    input  logic [EPOCH_W-1:0] max_epochs,
    input  logic               error,
    output logic               ready,
    output logic               busy,
    output logic               done,
    output logic               converged,
    output logic               init,
    output logic               ld_data,
    output logic               acc_en,
    output logic               add_b,
    output logic [1:0]         sel_mul,
    output logic               ld_mult,
    output logic               ld_w,
    output logic               ld_b,
    output logic [IDX_W-1:0]   in_idx,
    output logic [CNT_W-1:0]   sample_idx,
    output logic [EPOCH_W-1:0] epoch_cnt
);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_LOAD  = 4'd1,
        S_FETCH = 4'd2,
        S_ACC   = 4'd3,
        S_BIAS  = 4'd4,
        S_EVAL  = 4'd5,
        S_MUL1  = 4'd6,
        S_MUL2  = 4'd7,
        S_ADDW  = 4'd8,
        S_MULB  = 4'd9,
        S_ADDB  = 4'd10,
        S_DONE  = 4'd11
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_IN - 1);

    state_t             state;
    state_t             state_nxt;

    logic [CNT_W-1:0]   n_samples_q;
    logic [EPOCH_W-1:0] max_epochs_q;
    logic               err_flag;

    logic               last_idx;
    logic               last_sample;
    logic               limit_hit;
    logic               load_exit;
    logic               sample_end;
    state_t             sample_end_nxt;

    // Status decodes shared by the next-state and counter logic.
    always_comb begin
        last_idx    = (in_idx == LAST_IDX);
        last_sample = (sample_idx == (n_samples_q - CNT_W'(1)));
        limit_hit   = (max_epochs_q != '0) &&
                      (epoch_cnt == (max_epochs_q - EPOCH_W'(1)));
        load_exit   = (state == S_LOAD) && !start;
        // A sample finishes in EVAL when correct, or in ADDB after the bias update.
        sample_end  = ((state == S_EVAL) && !error) || (state == S_ADDB);
    end

    // Where a finished sample leads: next sample, next epoch, or stop.
    always_comb begin
        sample_end_nxt = S_FETCH;
        if (last_sample) begin
            if (!err_flag) begin
                sample_end_nxt = S_DONE;
            end else if (limit_hit) begin
                sample_end_nxt = S_DONE;
            end else begin
                sample_end_nxt = S_FETCH;
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (start) state_nxt = S_LOAD;
            S_LOAD: begin
                if (!start) begin
                    // n_samples is taken live here since it is captured on this same edge.
                    state_nxt = (n_samples == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: state_nxt = S_ACC;
            S_ACC:   if (last_idx) state_nxt = S_BIAS;
            S_BIAS:  state_nxt = S_EVAL;
            S_EVAL:  state_nxt = error ? S_MUL1 : sample_end_nxt;
            S_MUL1:  state_nxt = S_MUL2;
            S_MUL2:  state_nxt = S_ADDW;
            S_ADDW:  state_nxt = last_idx ? S_MULB : S_MUL1;
            S_MULB:  state_nxt = S_ADDB;
            S_ADDB:  state_nxt = sample_end_nxt;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Moore output decode: every strobe is a pure function of the state.
    always_comb begin
        ready   = (state == S_IDLE);
        busy    = (state != S_IDLE) && (state != S_DONE);
        done    = (state == S_DONE);
        init    = (state == S_LOAD);
        ld_data = (state == S_FETCH);
        acc_en  = (state == S_ACC);
        add_b   = (state == S_BIAS);
        ld_mult = (state == S_MUL1) || (state == S_MUL2) || (state == S_MULB);
        ld_w    = (state == S_ADDW);
        ld_b    = (state == S_ADDB);
        sel_mul = 2'd0;
        if (state == S_MUL2) sel_mul = 2'd1;
        if (state == S_MULB) sel_mul = 2'd2;
    end

    // Run configuration, captured when the host releases start.
    always_ff @(posedge clk) begin
        if (rst) begin
            n_samples_q  <= '0;
            max_epochs_q <= '0;
        end else if (load_exit) begin
            n_samples_q  <= n_samples;
            max_epochs_q <= max_epochs;
        end
    end

    // Weight index: walks 0..N_IN-1 during ACC and again across the update loop.
    always_ff @(posedge clk) begin
        if (rst) begin
            in_idx <= '0;
        end else begin
            case (state)
                S_FETCH: in_idx <= '0;
                S_ACC:   if (!last_idx) in_idx <= in_idx + IDX_W'(1);
                S_EVAL:  if (error) in_idx <= '0;
                S_ADDW:  if (!last_idx) in_idx <= in_idx + IDX_W'(1);
                default: in_idx <= in_idx;
            endcase
        end
    end

    // Sample address: advances per sample, rewinds when a new epoch starts.
    always_ff @(posedge clk) begin
        if (rst) begin
            sample_idx <= '0;
        end else if (load_exit) begin
            sample_idx <= '0;
        end else if (sample_end) begin
            if (!last_sample) begin
                sample_idx <= sample_idx + CNT_W'(1);
            end else if (err_flag && !limit_hit) begin
                sample_idx <= '0;
            end
        end
    end

    // Epoch counter: counts every epoch that ended with at least one error.
    always_ff @(posedge clk) begin
        if (rst) begin
            epoch_cnt <= '0;
        end else if (load_exit) begin
            epoch_cnt <= '0;
        end else if (sample_end && last_sample && err_flag) begin
            epoch_cnt <= epoch_cnt + EPOCH_W'(1);
        end
    end

    // Epoch error flag: set by any misclassified sample, cleared at epoch start.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_flag <= 1'b0;
        end else if (load_exit) begin
            err_flag <= 1'b0;
        end else if ((state == S_EVAL) && error) begin
            err_flag <= 1'b1;
        end else if (sample_end && last_sample && err_flag && !limit_hit) begin
            err_flag <= 1'b0;
        end
    end

    // Converged status: set by a clean epoch, held through DONE/IDLE until the next LOAD exit.
    always_ff @(posedge clk) begin
        if (rst) begin
            converged <= 1'b0;
        end else if (load_exit) begin
            converged <= 1'b0;
        end else if (sample_end && last_sample && !err_flag) begin
            converged <= 1'b1;
        end
    end

endmodule

// File: tb/tb_perceptron_train_ctrl.sv
// Bench for perceptron_train_ctrl: one N_IN=2 instance for the run scenarios, one N_IN=4 for index range and start toggling.
// Expected run results come from a behavioural epoch model pushed to a scoreboard queue at start.
// Outputs are sampled #1 after the rising edge or on the falling edge.
module tb_perceptron_train_ctrl;

    localparam int CNT_W   = 4;
    localparam int EPOCH_W = 8;

    typedef struct {
        int lat;
        int conv;
        int epoch;
        int ldw;
        int ldb;
        int ldd;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Instance A: N_IN=2
    logic               a_start;
    logic [CNT_W-1:0]   a_n_samples;
    logic [EPOCH_W-1:0] a_max_epochs;
    logic               a_error;
    logic               a_ready, a_busy, a_done, a_converged, a_init, a_ld_data;
    logic               a_acc_en, a_add_b, a_ld_mult, a_ld_w, a_ld_b;
    logic [1:0]         a_sel_mul;
    logic [0:0]         a_in_idx;
    logic [CNT_W-1:0]   a_sample_idx;
    logic [EPOCH_W-1:0] a_epoch_cnt;

    // Instance B: N_IN=4
    logic               b_start;
    logic [CNT_W-1:0]   b_n_samples;
    logic [EPOCH_W-1:0] b_max_epochs;
    logic               b_error;
    logic               b_ready, b_busy, b_done, b_converged, b_init, b_ld_data;
    logic               b_acc_en, b_add_b, b_ld_mult, b_ld_w, b_ld_b;
    logic [1:0]         b_sel_mul;
    logic [1:0]         b_in_idx;
    logic [CNT_W-1:0]   b_sample_idx;
    logic [EPOCH_W-1:0] b_epoch_cnt;

    int err_mode = 0;

    // error pattern: 0 never, 1 always, 2 only sample 2 of epoch 0
    assign a_error = (err_mode == 1) ? 1'b1 :
                     (err_mode == 2) ? ((a_epoch_cnt == '0) && (a_sample_idx == 4'd2)) : 1'b0;
    assign b_error = 1'b0;

    perceptron_train_ctrl #(.N_IN(2), .CNT_W(CNT_W), .EPOCH_W(EPOCH_W)) dut_a (
        .clk(clk), .rst(rst), .start(a_start), .n_samples(a_n_samples),
        .max_epochs(a_max_epochs), .error(a_error), .ready(a_ready), .busy(a_busy),
        .done(a_done), .converged(a_converged), .init(a_init), .ld_data(a_ld_data),
        .acc_en(a_acc_en), .add_b(a_add_b), .sel_mul(a_sel_mul), .ld_mult(a_ld_mult),
        .ld_w(a_ld_w), .ld_b(a_ld_b), .in_idx(a_in_idx), .sample_idx(a_sample_idx),
        .epoch_cnt(a_epoch_cnt)
    );

    perceptron_train_ctrl #(.N_IN(4), .CNT_W(CNT_W), .EPOCH_W(EPOCH_W)) dut_b (
        .clk(clk), .rst(rst), .start(b_start), .n_samples(b_n_samples),
        .max_epochs(b_max_epochs), .error(b_error), .ready(b_ready), .busy(b_busy),
        .done(b_done), .converged(b_converged), .init(b_init), .ld_data(b_ld_data),
        .acc_en(b_acc_en), .add_b(b_add_b), .sel_mul(b_sel_mul), .ld_mult(b_ld_mult),
        .ld_w(b_ld_w), .ld_b(b_ld_b), .in_idx(b_in_idx), .sample_idx(b_sample_idx),
        .epoch_cnt(b_epoch_cnt)
    );

    // Strobe activity monitor, sampled mid-cycle.
    logic clr_mon = 1'b1;
    int a_ldw_cnt, a_ldb_cnt, a_ldd_cnt, a_widx_bad;
    logic [0:0] a_widx_exp;
    int b_acc_cnt, b_idx_max, b_acc_bad, b_ldd_cnt;
    logic [1:0] b_acc_exp;

    always @(negedge clk) begin
        if (clr_mon) begin
            a_ldw_cnt = 0; a_ldb_cnt = 0; a_ldd_cnt = 0; a_widx_bad = 0; a_widx_exp = 1'b0;
            b_acc_cnt = 0; b_idx_max = 0; b_acc_bad = 0; b_ldd_cnt = 0; b_acc_exp = 2'd0;
        end else begin
            if (a_ld_w) begin
                a_ldw_cnt++;
                if (a_in_idx !== a_widx_exp) a_widx_bad++;
                a_widx_exp = ~a_widx_exp;
            end
            if (a_ld_b) a_ldb_cnt++;
            if (a_ld_data) a_ldd_cnt++;
            if (b_ld_data) b_ldd_cnt++;
            if (b_acc_en) begin
                b_acc_cnt++;
                if (int'(b_in_idx) > b_idx_max) b_idx_max = int'(b_in_idx);
                if (b_in_idx !== b_acc_exp) b_acc_bad++;
                b_acc_exp = b_acc_exp + 2'd1;
            end
        end
    end

    int total = 0;
    int bad   = 0;
    exp_t sbq[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Behavioural epoch model: per-sample cost and update counts.
    function automatic exp_t model(input int nin, input int n, input int maxe, input int mode);
        exp_t e;
        int   ep;
        bit   ef;
        bit   fin;
        bit   err;
        e = '{default: 0};
        if (n == 0) return e;
        ep  = 0;
        fin = 1'b0;
        while (!fin) begin
            ef = 1'b0;
            for (int s = 0; s < n; s++) begin
                err = (mode == 1) || ((mode == 2) && (ep == 0) && (s == 2));
                e.ldd++;
                if (err) begin
                    e.lat += 4 * nin + 5;
                    e.ldw += nin;
                    e.ldb++;
                    ef = 1'b1;
                end else begin
                    e.lat += nin + 3;
                end
            end
            if (!ef) begin
                e.conv = 1;
                fin    = 1'b1;
            end else begin
                ep++;
                if ((maxe != 0) && (ep == maxe)) fin = 1'b1;
            end
        end
        e.epoch = ep;
        return e;
    endfunction

    function automatic logic [10:0] a_strobes();
        return {a_init, a_ld_data, a_acc_en, a_add_b, a_ld_mult, a_ld_w, a_ld_b, a_done, a_busy, a_sel_mul != 2'd0, a_converged};
    endfunction

    task automatic run_a(input string tag, input int n, input int maxe, input int mode);
        int   lat;
        bit   hit;
        exp_t e;
        @(negedge clk);
        err_mode     = mode;
        a_n_samples  = CNT_W'(n);
        a_max_epochs = EPOCH_W'(maxe);
        clr_mon      = 1'b1;
        a_start      = 1'b1;
        sbq.push_back(model(2, n, maxe, mode));
        @(negedge clk);
        clr_mon = 1'b0;
        @(negedge clk);
        chk({tag, "_init_in_load"}, 32'(a_init), 32'd1);
        a_start = 1'b0;
        lat = -1;
        hit = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (a_done) begin
                hit = 1'b1;
                break;
            end
        end
        chk({tag, "_timeout"}, 32'(hit), 32'd1);
        e = sbq.pop_front();
        chk({tag, "_latency"}, 32'(lat), 32'(e.lat));
        chk({tag, "_converged"}, 32'(a_converged), 32'(e.conv));
        chk({tag, "_epoch_cnt"}, 32'(a_epoch_cnt), 32'(e.epoch));
        chk({tag, "_ld_w_cnt"}, 32'(a_ldw_cnt), 32'(e.ldw));
        chk({tag, "_ld_b_cnt"}, 32'(a_ldb_cnt), 32'(e.ldb));
        chk({tag, "_ld_data_cnt"}, 32'(a_ldd_cnt), 32'(e.ldd));
        chk({tag, "_w_idx_order"}, 32'(a_widx_bad), 32'd0);
        chk({tag, "_busy_in_done"}, 32'(a_busy), 32'd0);
        @(posedge clk);
        #1;
        chk({tag, "_done_one_cycle"}, 32'(a_done), 32'd0);
        chk({tag, "_ready_after"}, 32'(a_ready), 32'd1);
        chk({tag, "_converged_held"}, 32'(a_converged), 32'(e.conv));
    endtask

    initial begin
        int   lat;
        bit   hit;
        exp_t e;

        rst = 1'b1;
        a_start = 1'b0; a_n_samples = '0; a_max_epochs = '0;
        b_start = 1'b0; b_n_samples = '0; b_max_epochs = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 32'(a_ready), 32'd1);
        chk("rst_strobes", 32'(a_strobes()), 32'd0);
        chk("rst_sample_idx", 32'(a_sample_idx), 32'd0);
        chk("rst_epoch_cnt", 32'(a_epoch_cnt), 32'd0);
        chk("rst_in_idx", 32'(a_in_idx), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_a("clean", 4, 5, 0);
        run_a("allerr", 4, 3, 1);
        run_a("oneerr", 4, 0, 2);
        run_a("zero", 0, 5, 0);

        // Reset while in MUL2 of epoch 1.
        @(negedge clk);
        err_mode = 1; a_n_samples = 4'd4; a_max_epochs = 8'd3; a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if ((a_sel_mul == 2'd1) && (a_epoch_cnt == 8'd1)) begin
                hit = 1'b1;
                break;
            end
        end
        chk("midrst_reach_mul2", 32'(hit), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("midrst_ready", 32'(a_ready), 32'd1);
        chk("midrst_strobes", 32'(a_strobes()), 32'd0);
        chk("midrst_sample_idx", 32'(a_sample_idx), 32'd0);
        chk("midrst_epoch_cnt", 32'(a_epoch_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run_a("after_rst", 4, 5, 0);

        // N_IN=4 with start toggled during ACC.
        @(negedge clk);
        b_n_samples = 4'd2; b_max_epochs = 8'd0; clr_mon = 1'b1; b_start = 1'b1;
        sbq.push_back(model(4, 2, 0, 0));
        @(negedge clk);
        clr_mon = 1'b0;
        b_start = 1'b0;
        lat = -1;
        hit = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(posedge clk);
            #1;
            lat++;
            if (b_done) begin
                hit = 1'b1;
                break;
            end
            @(negedge clk);
            b_start = b_acc_en ? ~b_start : 1'b0;
        end
        b_start = 1'b0;
        chk("n4_timeout", 32'(hit), 32'd1);
        e = sbq.pop_front();
        chk("n4_latency", 32'(lat), 32'(e.lat));
        chk("n4_converged", 32'(b_converged), 32'(e.conv));
        chk("n4_epoch_cnt", 32'(b_epoch_cnt), 32'(e.epoch));
        chk("n4_ld_data_cnt", 32'(b_ldd_cnt), 32'(e.ldd));
        chk("n4_acc_cycles", 32'(b_acc_cnt), 32'd8);
        chk("n4_idx_max", 32'(b_idx_max), 32'd3);
        chk("n4_acc_order", 32'(b_acc_bad), 32'd0);
        @(posedge clk);
        #1;
        chk("n4_idle_after", 32'(b_ready), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/perceptron_train_ctrl.md
# perceptron_train_ctrl

Parametrised control unit for the perceptron training engine. It sequences N_IN-input training over a sample memory for repeated epochs until one epoch runs with no error (converged) or an epoch limit is hit. It drives the datapath (weight/bias registers, multiplier, accumulator, sample memory address) through Moore-decoded strobes. It also reports completion status to the host.

## Interface
Parameters:
- N_IN, 2: number of inputs/weights per sample (≥1)
- IDX_W, $clog2(N_IN) (min 1): width of in_idx
- CNT_W, 4: sample-counter width (up to 2^CNT_W−1 samples)
- EPOCH_W, 8: epoch-counter width

Ports:
- clk  in  1  clock; single clock domain
- rst  in  1  reset; synchronous, active-high
- start  in  1  level; held high while host loads alpha; training begins on the cycle after it drops
- n_samples  in  CNT_W  number of training samples; captured on LOAD exit
- max_epochs  in  EPOCH_W  epoch limit; 0 = unlimited; captured on LOAD exit
- error  in  1  datapath: sign(y) ≠ t; sampled only in EVAL
- ready  out  1  high in IDLE
- busy  out  1  high in every state except IDLE and DONE
- done  out  1  one-cycle pulse in DONE
- converged  out  1  registered; valid from DONE until next LOAD
- init  out  1  LOAD: load alpha, clear weights and bias
- ld_data  out  1  FETCH: load x[0..N_IN−1] and t from sample_idx; clear y
- acc_en  out  1  ACC: y += w[in_idx]·x[in_idx]
- add_b  out  1  BIAS: y += b
- sel_mul  out  2  0: t·x[in_idx]; 1: alpha·mult; 2: alpha·t
- ld_mult  out  1  load multiplier register
- ld_w  out  1  w[in_idx] += mult
- ld_b  out  1  b += mult
- in_idx  out  IDX_W  current weight index
- sample_idx  out  CNT_W  current sample address
- epoch_cnt  out  EPOCH_W  completed epochs in the current run

## Operation
States: IDLE, LOAD, FETCH, ACC, BIAS, EVAL, MUL1, MUL2, ADDW, MULB, ADDB, DONE.
- IDLE: start=1 → LOAD.
- LOAD: remains in LOAD while start=1. On exit, captures n_samples and max_epochs and clears sample_idx, epoch_cnt, err_flag and converged.
  - Captured n_samples=0 → DONE with converged=0.
  - Otherwise → FETCH.
- FETCH → ACC with in_idx=0.
- ACC: N_IN cycles, in_idx 0..N_IN−1 → BIAS.
- BIAS → EVAL.
- EVAL:
  - error=1: set err_flag, go to MUL1 with in_idx=0.
  - error=0: go to sample-end.
- MUL1 (sel_mul=0, ld_mult) → MUL2 (sel_mul=1, ld_mult) → ADDW (ld_w).
  - ADDW with in_idx<N_IN−1: increment in_idx, return to MUL1.
  - Otherwise → MULB (sel_mul=2, ld_mult) → ADDB (ld_b) → sample-end.
- Sample-end:
  - sample_idx<n_samples−1: increment sample_idx, go to FETCH.
  - Last sample, err_flag=0: converged=1, go to DONE.
  - Last sample, max_epochs≠0 and epoch_cnt==max_epochs−1: converged=0, epoch_cnt increments, go to DONE.
  - Otherwise: epoch_cnt increments (wraps at 2^EPOCH_W when unlimited), sample_idx=0, err_flag=0, go to FETCH.
- DONE → IDLE unconditionally.
- Strobes not listed for a state are 0. sel_mul=0 and in_idx holds its value outside the update states.
- start is ignored outside IDLE/LOAD.

## Timing
- Reset (synchronous, any state including mid-epoch): next cycle state=IDLE, ready=1, all other outputs 0, all counters and err_flag cleared.
- Error-free sample: N_IN+3 cycles (FETCH to EVAL).
- Sample with error: 4·N_IN+5 cycles.
- done is asserted N cycles after start falls, where N is the sum of the per-sample cycle counts.
- error must be valid in the EVAL cycle only. The datapath has one cycle (ACC/BIAS register write) before EVAL.
- ld_w/ld_b writes are visible to the next ACC of the following sample.

## Test plan
- N_IN=2, n_samples=4, max_epochs=5, error held 0: done pulses 20 cycles after LOAD exit; converged=1, epoch_cnt=0, zero ld_w pulses.
- N_IN=2, n_samples=4, max_epochs=3, error held 1: 156 cycles to done; converged=0, epoch_cnt=3; ld_w pulses=24, ld_b pulses=12; in_idx on ld_w cycles alternates 0,1.
- error=1 only on sample 2 of epoch 0, 0 afterwards: epoch 0 takes 28 cycles, epoch 1 takes 20; converged=1, epoch_cnt=1.
- n_samples=0: DONE on the cycle after LOAD exit; converged=0; no ld_data.
- Assert rst during MUL2 of epoch 1: next cycle ready=1, all strobes 0, sample_idx=0, epoch_cnt=0. A fresh start then runs normally.
- Toggle start during ACC: no effect on state. Use N_IN=4 to check in_idx reaching 3 and a 7-cycle error-free sample.
